// File: rtl/panel_control.sv
// Washing-machine front panel: debounces the four panel keys and runs the
// power/run state machine, end-of-cycle buzzer and automatic power-off.
module panel_control #(
  parameter int DEB_N    = 1_000_000,
  parameter int TICK_N   = 100_000_000,
  parameter int BEEP_SEC = 3,
  parameter int IDLE_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_start,
  input  logic       btn_model,
  input  logic       btn_water,
  input  logic       finish,
  output logic       power_light,
  output logic [1:0] run_state,
  output logic [2:0] current_model,
  output logic [2:0] current_water,
  output logic       buzzer
);

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam int K_POWER = 0;
  localparam int K_START = 1;
  localparam int K_MODEL = 2;
  localparam int K_WATER = 3;

  localparam logic [19:0] DEB_MAX  = 20'(DEB_N - 1);
  localparam logic [26:0] TICK_MAX = 27'(TICK_N - 1);
  localparam logic [3:0]  SEC_BEEP = 4'(BEEP_SEC);
  localparam logic [3:0]  SEC_IDLE = 4'(IDLE_SEC);

  localparam logic [1:0] RS_STOP  = 2'b00;
  localparam logic [1:0] RS_RUN   = 2'b01;
  localparam logic [1:0] RS_PAUSE = 2'b10;

  // ---------------------------------------------------------------------------
  // Key path: 2-FF synchronizer, stability counter, rising-edge press pulse.
  // ---------------------------------------------------------------------------
  logic [3:0]  keys;
  logic [3:0]  sync1, sync2, stable, press;
  logic [19:0] deb_cnt [4];

  assign keys = {btn_water, btn_model, btn_start, btn_power};

  // NOTE: the counter array is tiny, so it is reset like ordinary flops; a key
  // held through reset must restart debouncing from a known zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, which is
      // what forms the two-stage synchronizer.
      sync1 <= keys;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Power/run state machine with DONE-phase timers.
  // ---------------------------------------------------------------------------
  state_t      state, state_next;
  logic [26:0] ticks, ticks_next;
  logic [3:0]  secs, secs_next;
  logic [2:0]  model_next, water_next;
  logic [1:0]  run_next;

  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ticks_next = ticks;
    secs_next  = secs;
    model_next = current_model;
    water_next = current_water;

    case (state)
      S_OFF: begin
        if (press[K_POWER]) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (press[K_POWER]) begin
          state_next = S_OFF;
        end else begin
          if (press[K_START]) state_next = S_RUN;
          if (press[K_MODEL]) model_next = (current_model == 3'd5) ? 3'd0 : current_model + 3'd1;
          if (press[K_WATER]) water_next = (current_water == 3'd5) ? 3'd1 : current_water + 3'd1;
        end
      end
      S_RUN: begin
        if (press[K_POWER]) begin
          state_next = S_OFF;
        end else if (finish) begin
          state_next = S_DONE;
          ticks_next = '0;
          secs_next  = '0;
        end else if (press[K_START]) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press[K_POWER])      state_next = S_OFF;
        else if (press[K_START]) state_next = S_RUN;
      end
      S_DONE: begin
        if (ticks == TICK_MAX) begin
          ticks_next = '0;
          if (secs < SEC_IDLE) secs_next = secs + 4'd1;
        end else begin
          ticks_next = ticks + 27'd1;
        end
        // Leave on the edge where the seconds count arrives at the idle limit.
        if (press[K_POWER] || secs_next == SEC_IDLE) state_next = S_OFF;
      end
      default: state_next = S_OFF;
    endcase

    // OFF always carries the default selection, so IDLE is entered with it too.
    if (state_next == S_OFF) begin
      model_next = 3'd0;
      water_next = 3'd2;
    end

    case (state_next)
      S_RUN, S_DONE: run_next = RS_RUN;
      S_PAUSE:       run_next = RS_PAUSE;
      default:       run_next = RS_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_OFF;
      ticks         <= '0;
      secs          <= '0;
      current_model <= 3'd0;
      current_water <= 3'd2;
      power_light   <= 1'b0;
      run_state     <= RS_STOP;
      buzzer        <= 1'b0;
    end else begin
      state         <= state_next;
      ticks         <= ticks_next;
      secs          <= secs_next;
      current_model <= model_next;
      current_water <= water_next;
      power_light   <= (state_next != S_OFF);
      run_state     <= run_next;
      buzzer        <= (state_next == S_DONE) && (secs_next < SEC_BEEP);
    end
  end

endmodule

// File: tb/tb_panel_control.sv
// Self-checking bench for panel_control: directed test-plan steps followed by
// random key/finish traffic checked against a state-level reference model.
module tb_panel_control;

  localparam int DEB_N    = 4;
  localparam int TICK_N   = 10;
  localparam int BEEP_SEC = 3;
  localparam int IDLE_SEC = 10;

  // reference-model states
  localparam int M_OFF = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  localparam int K_POWER = 0, K_START = 1, K_MODEL = 2, K_WATER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_power = 1'b0, btn_start = 1'b0, btn_model = 1'b0, btn_water = 1'b0;
  logic       finish = 1'b0;
  logic       power_light;
  logic [1:0] run_state;
  logic [2:0] current_model, current_water;
  logic       buzzer;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  logic pl_prev = 1'b0;

  int m_st = M_OFF;
  int m_model = 0;
  int m_water = 2;

  panel_control #(
    .DEB_N(DEB_N), .TICK_N(TICK_N), .BEEP_SEC(BEEP_SEC), .IDLE_SEC(IDLE_SEC)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_power(btn_power), .btn_start(btn_start),
    .btn_model(btn_model), .btn_water(btn_water),
    .finish(finish),
    .power_light(power_light), .run_state(run_state),
    .current_model(current_model), .current_water(current_water),
    .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (power_light === 1'b1 && pl_prev !== 1'b1) rises++;
    pl_prev = power_light;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed hang, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_run(input int st);
    case (st)
      M_RUN, M_DONE: return 2'b01;
      M_PAUSE:       return 2'b10;
      default:       return 2'b00;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".power"}, power_light, (m_st != M_OFF));
    chk({tag, ".run"},   run_state, exp_run(m_st));
    chk({tag, ".model"}, current_model, m_model);
    chk({tag, ".water"}, current_water, m_water);
    chk({tag, ".buzzer"}, buzzer, (m_st == M_DONE));
  endtask

  task automatic set_btn(input int k, input logic v);
    case (k)
      K_POWER: btn_power = v;
      K_START: btn_start = v;
      K_MODEL: btn_model = v;
      default: btn_water = v;
    endcase
  endtask

  // Reference behaviour of one accepted key press.
  task automatic model_press(input int k);
    case (k)
      K_POWER: begin
        m_st = (m_st == M_OFF) ? M_IDLE : M_OFF;
        m_model = 0;
        m_water = 2;
      end
      K_START: begin
        if (m_st == M_IDLE || m_st == M_PAUSE) m_st = M_RUN;
        else if (m_st == M_RUN) m_st = M_PAUSE;
      end
      K_MODEL: if (m_st == M_IDLE) m_model = (m_model + 1) % 6;
      default: if (m_st == M_IDLE) m_water = (m_water % 5) + 1;
    endcase
  endtask

  task automatic press(input int k, input int hold, input int gap);
    @(negedge clk);
    set_btn(k, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(k, 1'b0);
    repeat (gap) @(negedge clk);
    model_press(k);
  endtask

  task automatic glitch(input int k, input int len);
    @(negedge clk);
    set_btn(k, 1'b1);
    repeat (len) @(negedge clk);
    set_btn(k, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int bz, pl, r, k;
    int exp_models [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_waters [4] = '{3, 4, 5, 1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");

    // 1. Power on with a 10-cycle press, then a 3-cycle glitch
    rises = 0;
    press(K_POWER, 10, 10);
    chk("pwr_on.rises", rises, 1);
    check_all("pwr_on");
    glitch(K_POWER, 3);
    chk("glitch.rises", rises, 1);
    check_all("glitch");

    // 2. Selection wrap
    for (int i = 0; i < 7; i++) begin
      press(K_MODEL, 8, 8);
      chk("model_seq", current_model, exp_models[i]);
      chk("model_ref", current_model, m_model);
    end
    for (int i = 0; i < 4; i++) begin
      press(K_WATER, 8, 8);
      chk("water_seq", current_water, exp_waters[i]);
    end
    check_all("select");

    // 3. Start / pause / resume, then model ignored while running
    press(K_START, 8, 8); chk("start1", run_state, 2'b01);
    press(K_START, 8, 8); chk("start2", run_state, 2'b10);
    press(K_START, 8, 8); chk("start3", run_state, 2'b01);
    press(K_MODEL, 8, 8);
    check_all("model_in_run");

    // 4. finish coincides with the start press pulse: the pulse is sampled by
    // the state machine on the 7th edge after the key is first driven.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    m_st = M_DONE;
    check_all("done_entry");
    bz = 0;
    pl = 0;
    for (int i = 0; i < 120; i++) begin
      if (buzzer === 1'b1) bz++;
      if (power_light === 1'b1) pl++;
      if (i == 1) btn_start = 1'b0;
      if (i == 3) btn_model = 1'b1;
      if (i == 12) btn_model = 1'b0;
      if (i == 20) begin
        chk("done.model_ignored", current_model, m_model);
        chk("done.run_held", run_state, 2'b01);
      end
      @(negedge clk);
    end
    chk("done.buzzer_cycles", bz, BEEP_SEC * TICK_N);
    chk("done.power_cycles", pl, IDLE_SEC * TICK_N);
    m_st = M_OFF; m_model = 0; m_water = 2;
    check_all("auto_off");

    // 5. Power-off priority from PAUSE with a non-default selection
    press(K_POWER, 8, 8);
    repeat (4) press(K_MODEL, 8, 8);
    repeat (3) press(K_WATER, 8, 8);
    chk("pre_pause.model", current_model, 4);
    chk("pre_pause.water", current_water, 5);
    press(K_START, 8, 8);
    press(K_START, 8, 8);
    check_all("paused");
    press(K_POWER, 8, 8);
    check_all("pause_pwr_off");
    press(K_POWER, 8, 8);
    check_all("pwr_on_again");

    // 6. Reset in RUN with start held
    press(K_START, 8, 8);
    check_all("run_before_rst");
    @(negedge clk);
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_st = M_OFF; m_model = 0; m_water = 2;
    check_all("after_rst");
    r = rises;
    repeat (DEB_N + 8) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_held_start.rises", rises, r);
    check_all("rst_held_start");

    // Random traffic against the reference model
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 7) begin
        k = r / 2;
        press(k, $urandom_range(6, 12), $urandom_range(8, 12));
        check_all("rnd_press");
      end else if (r == 8) begin
        glitch($urandom_range(0, 3), $urandom_range(1, 3));
        check_all("rnd_glitch");
      end else begin
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        if (m_st == M_RUN) begin
          m_st = M_DONE;
          check_all("rnd_done");
          if ($urandom_range(0, 1) == 1) begin
            press(K_POWER, 8, 8);
          end else begin
            repeat (IDLE_SEC * TICK_N) @(negedge clk);
            m_st = M_OFF; m_model = 0; m_water = 2;
          end
        end
        check_all("rnd_finish");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
